// File: rtl/spi1_wb_target.sv
// SPI mode-0 target that turns short command frames into single pipelined
// Wishbone cycles; POCI returns the data of the most recent completed read.
module spi1_wb_target #(
  parameter int unsigned WB_DATA_WIDTH = 8,
  parameter int unsigned WB_ADDR_WIDTH = 20
) (
  input  logic                     clock_i,
  input  logic                     reset_ni,
  input  logic                     spi_sck_i,
  input  logic                     spi_cs_ni,
  input  logic                     spi_pico_i,
  output logic                     spi_poci_o,
  output logic                     spi_stall_o,
  output logic [WB_ADDR_WIDTH-1:0] wb_adr_o,
  output logic [WB_DATA_WIDTH-1:0] wb_dat_o,
  input  logic [WB_DATA_WIDTH-1:0] wb_dat_i,
  output logic                     wb_we_o,
  output logic                     wb_cyc_o,
  output logic                     wb_stb_o,
  input  logic                     wb_ack_i,
  input  logic                     wb_stall_i
);

  localparam int unsigned AW = WB_ADDR_WIDTH;
  localparam int unsigned DW = WB_DATA_WIDTH;
  localparam int unsigned BW = 3;

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR_HI, ADDR_LO, DATA, WB_REQ, WB_WAIT, DONE
  } state_t;

  state_t          state;
  logic            sck_meta, sck_sync, sck_prev;
  logic            cs_meta, cs_sync, cs_prev;
  logic            pico_meta, pico_sync;
  logic [BW-1:0]   bit_cnt;
  logic [6:0]      rx_shift;
  logic [DW-1:0]   tx_byte;
  logic [DW-1:0]   resp;
  logic [AW-1:0]   addr;
  logic [AW-1:0]   addr_stage;
  logic            we_q;

  logic            sck_rise_c, sck_fall_c, cs_fall_c, cs_rise_c;
  logic [7:0]      rx_next_c;
  logic            byte_done_c;

  // Two-flop synchronizers plus one history flop for edge detection
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      sck_meta  <= 1'b0;
      sck_sync  <= 1'b0;
      sck_prev  <= 1'b0;
      cs_meta   <= 1'b1;
      cs_sync   <= 1'b1;
      cs_prev   <= 1'b1;
      pico_meta <= 1'b0;
      pico_sync <= 1'b0;
    end else begin
      sck_meta  <= spi_sck_i;
      sck_sync  <= sck_meta;
      sck_prev  <= sck_sync;
      cs_meta   <= spi_cs_ni;
      cs_sync   <= cs_meta;
      cs_prev   <= cs_sync;
      pico_meta <= spi_pico_i;
      pico_sync <= pico_meta;
    end
  end

  assign sck_rise_c  = sck_sync & ~sck_prev;
  assign sck_fall_c  = ~sck_sync & sck_prev;
  assign cs_fall_c   = ~cs_sync & cs_prev;
  assign cs_rise_c   = cs_sync & ~cs_prev;
  assign rx_next_c   = {rx_shift, pico_sync};
  assign byte_done_c = sck_rise_c & ~cs_sync & (bit_cnt == BW'(7));

  // Bit-level shifter; the response byte is snapshotted at each byte boundary
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      bit_cnt    <= '0;
      rx_shift   <= '0;
      tx_byte    <= '0;
      spi_poci_o <= 1'b0;
    end else if (cs_fall_c) begin
      bit_cnt    <= '0;
      rx_shift   <= '0;
      tx_byte    <= resp;
      spi_poci_o <= resp[DW-1];
    end else if (cs_sync) begin
      bit_cnt    <= '0;
    end else begin
      if (sck_rise_c) begin
        rx_shift <= rx_next_c[6:0];
        bit_cnt  <= bit_cnt + BW'(1);
      end
      if (sck_fall_c) begin
        if (bit_cnt == '0) begin
          tx_byte    <= resp;
          spi_poci_o <= resp[DW-1];
        end else begin
          spi_poci_o <= tx_byte[BW'(7) - bit_cnt];
        end
      end
    end
  end

  // Frame decoder and Wishbone master
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state       <= IDLE;
      addr        <= '0;
      addr_stage  <= '0;
      we_q        <= 1'b0;
      resp        <= '0;
      spi_stall_o <= 1'b0;
      wb_adr_o    <= '0;
      wb_dat_o    <= '0;
      wb_we_o     <= 1'b0;
      wb_cyc_o    <= 1'b0;
      wb_stb_o    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cs_fall_c) begin
            state       <= CMD;
            spi_stall_o <= 1'b1;
          end
        end
        CMD: begin
          if (cs_rise_c) begin
            state       <= IDLE;
            spi_stall_o <= 1'b0;
          end else if (byte_done_c) begin
            we_q <= rx_next_c[7];
            if (rx_next_c[6]) begin
              addr_stage[19:16] <= rx_next_c[3:0];
              state             <= ADDR_HI;
            end else if (rx_next_c[7]) begin
              addr_stage <= addr;
              state      <= DATA;
            end else begin
              wb_adr_o <= addr;
              wb_we_o  <= 1'b0;
              wb_cyc_o <= 1'b1;
              wb_stb_o <= 1'b1;
              state    <= WB_REQ;
            end
          end
        end
        ADDR_HI: begin
          if (cs_rise_c) begin
            state       <= IDLE;
            spi_stall_o <= 1'b0;
          end else if (byte_done_c) begin
            addr_stage[15:8] <= rx_next_c;
            state            <= ADDR_LO;
          end
        end
        ADDR_LO: begin
          if (cs_rise_c) begin
            state       <= IDLE;
            spi_stall_o <= 1'b0;
          end else if (byte_done_c) begin
            if (we_q) begin
              addr_stage[7:0] <= rx_next_c;
              state           <= DATA;
            end else begin
              addr     <= {addr_stage[19:8], rx_next_c};
              wb_adr_o <= {addr_stage[19:8], rx_next_c};
              wb_we_o  <= 1'b0;
              wb_cyc_o <= 1'b1;
              wb_stb_o <= 1'b1;
              state    <= WB_REQ;
            end
          end
        end
        DATA: begin
          if (cs_rise_c) begin
            state       <= IDLE;
            spi_stall_o <= 1'b0;
          end else if (byte_done_c) begin
            addr     <= addr_stage;
            wb_adr_o <= addr_stage;
            wb_dat_o <= rx_next_c;
            wb_we_o  <= 1'b1;
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            state    <= WB_REQ;
          end
        end
        WB_REQ: begin
          if (!wb_stall_i) begin
            wb_stb_o <= 1'b0;
            state    <= WB_WAIT;
          end
        end
        WB_WAIT: begin
          // CS may already be high here; the cycle still completes
          if (wb_ack_i) begin
            if (!wb_we_o) resp <= wb_dat_i;
            addr        <= addr + AW'(1);
            wb_cyc_o    <= 1'b0;
            wb_we_o     <= 1'b0;
            spi_stall_o <= 1'b0;
            state       <= DONE;
          end
        end
        DONE: begin
          if (cs_sync) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi1_wb_target.sv
// Directed bench for spi1_wb_target: SPI initiator, Wishbone memory slave,
// transaction-level reference model and a per-cycle bus monitor.
module tb_spi1_wb_target;

  typedef logic [7:0] bq_t[$];

  localparam time SCK_HALF = 80;

  logic        clock_i = 1'b0;
  logic        reset_ni = 1'b0;
  logic        spi_sck_i = 1'b0;
  logic        spi_cs_ni = 1'b1;
  logic        spi_pico_i = 1'b0;
  logic        spi_poci_o, spi_stall_o;
  logic [19:0] wb_adr_o;
  logic [7:0]  wb_dat_o;
  logic [7:0]  wb_dat_i = 8'h00;
  logic        wb_we_o, wb_cyc_o, wb_stb_o;
  logic        wb_ack_i = 1'b0;
  logic        wb_stall_i = 1'b0;

  spi1_wb_target #(.WB_DATA_WIDTH(8), .WB_ADDR_WIDTH(20)) dut (
    .clock_i(clock_i), .reset_ni(reset_ni),
    .spi_sck_i(spi_sck_i), .spi_cs_ni(spi_cs_ni), .spi_pico_i(spi_pico_i),
    .spi_poci_o(spi_poci_o), .spi_stall_o(spi_stall_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_ack_i(wb_ack_i), .wb_stall_i(wb_stall_i)
  );

  always #5 clock_i = ~clock_i;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference state: address register, response register, memory
  logic [7:0]  mem [logic [19:0]];
  logic [19:0] m_addr = 20'h0;
  logic [7:0]  m_resp = 8'h00;
  logic        exp_cycle = 1'b0;
  logic [19:0] exp_adr = 20'h0;
  logic        exp_we = 1'b0;
  logic [7:0]  exp_dat = 8'h00;

  function automatic logic [7:0] get_mem(input logic [19:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  // Decide from the frame bytes whether a bus cycle must happen, and its contents
  task automatic predict(input bq_t b);
    int need;
    logic [7:0] cmd;
    cmd  = (b.size() > 0) ? b[0] : 8'h00;
    need = 1 + (cmd[6] ? 2 : 0) + (cmd[7] ? 1 : 0);
    if (b.size() < need) begin
      exp_cycle = 1'b0;
    end else begin
      exp_cycle = 1'b1;
      exp_we    = cmd[7];
      exp_adr   = cmd[6] ? {cmd[3:0], b[1], b[2]} : m_addr;
      exp_dat   = cmd[7] ? b[need-1] : 8'h00;
    end
  endtask

  // Wishbone slave with programmable stall length and ack latency
  int          stall_len = 0;
  int          ack_lat = 1;
  int          sl_phase = 0;
  int          sl_cnt = 0;
  int          n_req = 0;
  logic [19:0] last_adr = 20'h0;
  logic        last_we = 1'b0;
  logic [7:0]  last_dat = 8'h00;

  initial begin
    forever begin
      @(negedge clock_i);
      if (!reset_ni) begin
        sl_phase = 0;
        wb_ack_i = 1'b0;
        wb_stall_i = 1'b0;
      end else begin
        case (sl_phase)
          0: begin
            wb_ack_i = 1'b0;
            if (wb_cyc_o && wb_stb_o) begin
              n_req++;
              last_adr = wb_adr_o;
              last_we  = wb_we_o;
              last_dat = wb_dat_o;
              if (stall_len > 0) begin
                wb_stall_i = 1'b1;
                sl_cnt = stall_len;
                sl_phase = 1;
              end else begin
                wb_stall_i = 1'b0;
                sl_cnt = ack_lat;
                sl_phase = 2;
              end
            end
          end
          1: begin
            sl_cnt--;
            if (sl_cnt == 0) begin
              wb_stall_i = 1'b0;
              sl_cnt = ack_lat;
              sl_phase = 2;
            end
          end
          2: begin
            if (sl_cnt <= 1) begin
              wb_ack_i = 1'b1;
              wb_dat_i = get_mem(last_adr);
              if (last_we) mem[last_adr] = last_dat;
              sl_phase = 3;
            end else begin
              sl_cnt--;
            end
          end
          default: begin
            wb_ack_i = 1'b0;
            sl_phase = 0;
          end
        endcase
      end
    end
  end

  // Per-cycle monitor comparing the bus against the model's expectation
  int stb_cnt = 0;
  int cyc_cnt = 0;
  initial begin
    logic p_ack, p_acc, p_valid;
    p_ack = 1'b0; p_acc = 1'b0; p_valid = 1'b0;
    forever begin
      @(negedge clock_i);
      #1;
      if (!reset_ni) begin
        p_valid = 1'b0;
      end else begin
        if (p_valid && p_ack) begin
          check("stall_after_ack", 32'(spi_stall_o), 32'(0));
          check("cyc_after_ack", 32'(wb_cyc_o), 32'(0));
        end
        if (p_valid && p_acc) check("stb_after_accept", 32'(wb_stb_o), 32'(0));
        if (!exp_cycle) begin
          check("unexpected_cyc", 32'(wb_cyc_o), 32'(0));
        end else if (wb_cyc_o) begin
          cyc_cnt++;
          if (wb_stb_o) stb_cnt++;
          check("bus_adr", 32'(wb_adr_o), 32'(exp_adr));
          check("bus_we", 32'(wb_we_o), 32'(exp_we));
          if (exp_we) check("bus_dat", 32'(wb_dat_o), 32'(exp_dat));
          check("stall_in_cycle", 32'(spi_stall_o), 32'(1));
        end
        p_ack = wb_ack_i;
        p_acc = wb_cyc_o && wb_stb_o && !wb_stall_i;
        p_valid = 1'b1;
      end
    end
  end

  task automatic mk(input logic [31:0] v, input int n, output bq_t q);
    q = {};
    for (int i = n - 1; i >= 0; i--) q.push_back(v[8*i +: 8]);
  endtask

  // Mode-0 initiator: optional trailing partial byte, then CS release
  task automatic xfer(input bq_t b, input int extra_bits, output bq_t rx);
    logic [7:0] r;
    int k;
    rx = {};
    r = 8'h00;
    spi_cs_ni = 1'b0;
    k = 0;
    while (!spi_stall_o && k < 8) begin
      @(negedge clock_i);
      k++;
    end
    check("stall_rise", 32'(spi_stall_o), 32'(1));
    for (int i = 0; i < b.size(); i++) begin
      for (int j = 7; j >= 0; j--) begin
        spi_pico_i = b[i][j];
        #(SCK_HALF);
        spi_sck_i = 1'b1;
        r[j] = spi_poci_o;
        #(SCK_HALF);
        spi_sck_i = 1'b0;
      end
      rx.push_back(r);
    end
    for (int j = 0; j < extra_bits; j++) begin
      spi_pico_i = 1'b1;
      #(SCK_HALF);
      spi_sck_i = 1'b1;
      #(SCK_HALF);
      spi_sck_i = 1'b0;
    end
    #(SCK_HALF);
    spi_cs_ni = 1'b1;
  endtask

  task automatic run(input bq_t b, input int extra_bits, input string tag, output bq_t rx);
    logic [7:0] exp_poci;
    int n0;
    int k;
    exp_poci = m_resp;
    predict(b);
    stb_cnt = 0;
    cyc_cnt = 0;
    n0 = n_req;
    xfer(b, extra_bits, rx);
    k = 0;
    while ((spi_stall_o || wb_cyc_o) && k < 400) begin
      @(negedge clock_i);
      k++;
    end
    check({tag, "_idle"}, 32'(spi_stall_o || wb_cyc_o), 32'(0));
    foreach (rx[i]) check({tag, "_poci"}, 32'(rx[i]), 32'(exp_poci));
    check({tag, "_ncyc"}, 32'(n_req - n0), exp_cycle ? 32'(1) : 32'(0));
    if (exp_cycle) begin
      if (!exp_we) m_resp = get_mem(exp_adr);
      m_addr = exp_adr + 20'd1;
    end
    exp_cycle = 1'b0;
    #200;
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bq_t q, rx;
    int k;
    repeat (3) @(negedge clock_i);
    #1;
    check("rst_cyc", 32'(wb_cyc_o), 32'(0));
    check("rst_stb", 32'(wb_stb_o), 32'(0));
    check("rst_we", 32'(wb_we_o), 32'(0));
    check("rst_adr", 32'(wb_adr_o), 32'(0));
    check("rst_dat", 32'(wb_dat_o), 32'(0));
    check("rst_stall", 32'(spi_stall_o), 32'(0));
    check("rst_poci", 32'(spi_poci_o), 32'(0));
    reset_ni = 1'b1;
    repeat (4) @(negedge clock_i);

    mk(32'hC12345A5, 4, q); run(q, 0, "wr", rx);
    check("wr_adr", 32'(last_adr), 32'h12345);
    check("wr_we", 32'(last_we), 32'(1));
    check("wr_dat", 32'(last_dat), 32'hA5);

    mem[20'h12345] = 8'h5A;
    mk(32'h00412345, 3, q); run(q, 0, "rd", rx);
    check("rd_adr", 32'(last_adr), 32'h12345);

    mem[20'h12346] = 8'h3C;
    mk(32'h0, 1, q); run(q, 0, "rn", rx);
    check("rn_poci_lit", 32'(rx[0]), 32'h5A);
    check("rn_adr", 32'(last_adr), 32'h12346);

    mem[20'h12347] = 8'h81;
    stall_len = 5; ack_lat = 3;
    mk(32'h0, 1, q); run(q, 0, "wst", rx);
    check("wst_poci_lit", 32'(rx[0]), 32'h3C);
    check("wst_adr", 32'(last_adr), 32'h12347);
    check("wst_stb_cycles", 32'(stb_cnt), 32'(6));
    check("wst_cyc_cycles", 32'(cyc_cnt), 32'(9));

    mem[20'h12348] = 8'h42;
    stall_len = 25; ack_lat = 2;
    mk(32'h0, 1, q); run(q, 0, "late", rx);
    stall_len = 0; ack_lat = 1;

    mk(32'h0000C123, 2, q); run(q, 0, "abort", rx);
    mem[20'h12349] = 8'h18;
    mk(32'h0, 1, q); run(q, 0, "abn", rx);
    check("abn_adr", 32'(last_adr), 32'h12349);
    check("abn_poci_lit", 32'(rx[0]), 32'h42);

    mk(32'h00C12345, 3, q); run(q, 4, "part", rx);
    mk(32'h0, 1, q); run(q, 0, "ptn", rx);
    mk(32'h00807799, 3, q); run(q, 0, "xtra", rx);
    mem[20'h12300] = 8'hE7;
    mk(32'h00712300, 3, q); run(q, 0, "ign", rx);
    check("ign_adr", 32'(last_adr), 32'h12300);

    mem[20'h00000] = 8'h96;
    mk(32'hCFFFFF11, 4, q); run(q, 0, "wrap_w", rx);
    check("wrap_w_adr", 32'(last_adr), 32'hFFFFF);
    mk(32'h0, 1, q); run(q, 0, "wrap_r", rx);
    check("wrap_r_adr", 32'(last_adr), 32'h00000);

    // Reset while the slave withholds ack
    ack_lat = 30;
    mk(32'h0, 1, q);
    predict(q);
    xfer(q, 0, rx);
    k = 0;
    while (!(wb_cyc_o && !wb_stb_o) && k < 100) begin
      @(negedge clock_i);
      k++;
    end
    check("rst_wait_reached", 32'(wb_cyc_o && !wb_stb_o), 32'(1));
    #2;
    reset_ni = 1'b0;
    #1;
    check("mid_rst_cyc", 32'(wb_cyc_o), 32'(0));
    check("mid_rst_stb", 32'(wb_stb_o), 32'(0));
    check("mid_rst_stall", 32'(spi_stall_o), 32'(0));
    check("mid_rst_adr", 32'(wb_adr_o), 32'(0));
    exp_cycle = 1'b0;
    m_addr = 20'h0;
    m_resp = 8'h00;
    ack_lat = 1;
    repeat (3) @(negedge clock_i);
    reset_ni = 1'b1;
    repeat (4) @(negedge clock_i);

    mk(32'h0, 1, q); run(q, 0, "post_rst", rx);
    check("post_rst_adr", 32'(last_adr), 32'h00000);
    check("post_rst_poci_lit", 32'(rx[0]), 32'h00);
    mk(32'h0, 1, q); run(q, 0, "post_rst2", rx);
    check("post_rst2_adr", 32'(last_adr), 32'h00001);
    check("post_rst2_poci_lit", 32'(rx[0]), 32'h96);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
